// File: rtl/register_write_arbiter_if.sv
// Bus bundle between three write requesters and the shared-register arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface register_write_arbiter_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);
  logic [2:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [2:0]       grant;
  logic             enable;
  logic [WIDTH-1:0] Data;
  logic [2:0]       done;
  logic [1:0]       owner;
  logic [CNT_W-1:0] wr_count;
  logic [WIDTH-1:0] Q;

  modport slave (
    input  req, d0, d1, d2,
    output grant, enable, Data, done, owner, wr_count, Q
  );

  modport master (
    output req, d0, d1, d2,
    input  grant, enable, Data, done, owner, wr_count, Q
  );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter granting one of three requesters a single write into a
// shared register; each write walks IDLE -> GRANT -> DONE, all outputs registered.
module register_write_arbiter #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  register_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       win_reg, win_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [2:0]       grant_reg, grant_next;
  logic [2:0]       done_reg, done_next;
  logic             enable_reg, enable_next;
  logic [1:0]       owner_reg, owner_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // Candidate order ptr, ptr+1, ptr+2 (mod 3) and whether each is requesting.
  logic [1:0] cand_idx [3];
  logic [2:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cand
      logic [2:0] sum;
      assign sum           = {1'b0, ptr_reg} + 3'(gi);
      assign cand_idx[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      assign cand_hit[gi]  = (cand_idx[gi] == 2'd0) ? bus.req[0] :
                             (cand_idx[gi] == 2'd1) ? bus.req[1] : bus.req[2];
    end
  endgenerate

  logic [1:0]       pick_idx;
  logic [WIDTH-1:0] pick_data;

  always_comb begin
    pick_idx = cand_idx[2];
    if (cand_hit[0]) begin
      pick_idx = cand_idx[0];
    end else if (cand_hit[1]) begin
      pick_idx = cand_idx[1];
    end
    case (pick_idx)
      2'd0:    pick_data = bus.d0;
      2'd1:    pick_data = bus.d1;
      default: pick_data = bus.d2;
    endcase
  end

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    onehot = 3'b001 << idx;
  endfunction

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    win_next    = win_reg;
    data_next   = data_reg;
    q_next      = q_reg;
    grant_next  = 3'b000;
    done_next   = 3'b000;
    enable_next = 1'b0;
    owner_next  = owner_reg;
    count_next  = count_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req != 3'b000) begin
          state_next  = GRANT;
          win_next    = pick_idx;
          data_next   = pick_data;
          grant_next  = onehot(pick_idx);
          enable_next = 1'b1;
        end
      end
      GRANT: begin
        // The write commits regardless of req/d changes since latching.
        state_next = DONE;
        q_next     = data_reg;
        owner_next = win_reg;
        done_next  = onehot(win_reg);
        ptr_next   = (win_reg == 2'd2) ? 2'd0 : win_reg + 2'd1;
        if (count_reg != {CNT_W{1'b1}}) begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= 2'd0;
      win_reg    <= 2'd0;
      data_reg   <= '0;
      q_reg      <= '0;
      grant_reg  <= 3'b000;
      done_reg   <= 3'b000;
      enable_reg <= 1'b0;
      owner_reg  <= 2'd0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      win_reg    <= win_next;
      data_reg   <= data_next;
      q_reg      <= q_next;
      grant_reg  <= grant_next;
      done_reg   <= done_next;
      enable_reg <= enable_next;
      owner_reg  <= owner_next;
      count_reg  <= count_next;
    end
  end

  assign bus.grant    = grant_reg;
  assign bus.enable   = enable_reg;
  assign bus.Data     = data_reg;
  assign bus.done     = done_reg;
  assign bus.owner    = owner_reg;
  assign bus.wr_count = count_reg;
  assign bus.Q        = q_reg;

endmodule
